// File: rtl/tmr_pkg.sv
// Shared definitions for the wake-up compare timer: register offsets and field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: bus data width, register select encoding (adr[3:2]),
// CTRL bit positions and STATUS bit position.
package tmr_pkg;

  localparam int WB_DW = 32;

  // Register select, taken from byte address bits [3:2].
  typedef enum logic [1:0] {
    ADR_CTRL    = 2'd0,
    ADR_COUNT   = 2'd1,
    ADR_COMPARE = 2'd2,
    ADR_STATUS  = 2'd3
  } tmr_reg_e;

  // CTRL fields
  localparam int CTRL_EN           = 0;
  localparam int CTRL_PERIODIC     = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  // STATUS fields
  localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/wake_timer_wb_if.sv
// Wishbone-style register bus bundle between a master and the wake-up timer.
// Latency: n/a (wires only).
// Backpressure: none; the slave acks every access one cycle after cyc is seen.
//
// Signals: adr (byte address), dat (write data), we (write enable), cyc (cycle/strobe),
// rdt (read data, valid with ack), ack (single-cycle acknowledge).
interface wake_timer_wb_if;
  import tmr_pkg::*;

  logic [WB_DW-1:0] adr;
  logic [WB_DW-1:0] dat;
  logic             we;
  logic             cyc;
  logic [WB_DW-1:0] rdt;
  logic             ack;

  modport master (
    output adr, dat, we, cyc,
    input  rdt, ack
  );

  modport slave (
    input  adr, dat, we, cyc,
    output rdt, ack
  );

endinterface

// File: rtl/tmr_prescaler.sv
// Prescaler for the wake-up timer: counts 0..reload and emits a one-cycle tick at the top.
// Latency: tick is combinational from the current count; the count updates on the next clk edge.
// Backpressure: none; en=0 freezes the count, clear restarts it from 0.
//
// Ports: clk, rst (sync, active-high), en (count enable), clear (restart from 0),
// reload (terminal value, 0 = tick every enabled cycle), tick (count == reload while enabled).
module tmr_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [PRE_W-1:0] reload,
  output logic             tick
);

  logic [PRE_W-1:0] pre;

  // Exact compare: if reload is lowered below the running count while enabled,
  // the count runs on and wraps before it ticks again.
  assign tick = en & (pre == reload);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (clear || tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/wake_timer_wb.sv
// Bus-mapped compare timer on the always-on clock; raises the wake-up request on compare match.
// Latency: bus ack/rdt one cycle after cyc; match flag and irq register on the tick edge.
// Backpressure: none; every access is acked exactly once, held cyc gives ack every other cycle.
//
// Ports: i_clk (always-on clock), i_rst (sync, active-high), wb_tmr (slave side of the
// register bus: CTRL/COUNT/COMPARE/STATUS at adr[3:2]), o_timer_irq (registered MATCH & IRQ_EN).
module wake_timer_wb
  import tmr_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  wake_timer_wb_if.slave  wb_tmr,
  output logic            o_timer_irq
);

  // Register state
  logic             en_q, periodic_q, irq_en_q, match_q, irq_q;
  logic [PRE_W-1:0] prescale_q;
  logic [CNT_W-1:0] count_q, compare_q;

  // Bus state
  logic             ack_q;
  logic [WB_DW-1:0] rdt_q;

  // Next-state values
  logic             en_n, periodic_n, irq_en_n, match_n;
  logic [PRE_W-1:0] prescale_n;
  logic [CNT_W-1:0] count_n, compare_n;

  // Decode
  logic     acc, wr;
  logic     wr_ctrl, wr_count, wr_compare, wr_status;
  tmr_reg_e sel;
  logic     tick, hit;
  logic [WB_DW-1:0] rd_dat;

  // Address bits outside [3:2] are don't-care.
  logic unused_adr;
  assign unused_adr = ^{wb_tmr.adr[WB_DW-1:4], wb_tmr.adr[1:0]};

  // An access is taken on the cycle cyc is seen with no ack outstanding.
  assign acc = wb_tmr.cyc & ~ack_q;
  assign wr  = acc & wb_tmr.we;
  assign sel = tmr_reg_e'(wb_tmr.adr[3:2]);

  assign wr_ctrl    = wr & (sel == ADR_CTRL);
  assign wr_count   = wr & (sel == ADR_COUNT);
  assign wr_compare = wr & (sel == ADR_COMPARE);
  assign wr_status  = wr & (sel == ADR_STATUS);

  // A COUNT write also restarts the prescale interval.
  tmr_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (i_clk),
    .rst    (i_rst),
    .en     (en_q),
    .clear  (wr_count),
    .reload (prescale_q),
    .tick   (tick)
  );

  // Match is judged against the compare value held before this cycle's writes.
  assign hit = (count_q == compare_q);

  always_comb begin
    en_n       = en_q;
    periodic_n = periodic_q;
    irq_en_n   = irq_en_q;
    prescale_n = prescale_q;
    count_n    = count_q;
    compare_n  = compare_q;
    match_n    = match_q;

    if (wr_ctrl) begin
      en_n       = wb_tmr.dat[CTRL_EN];
      periodic_n = wb_tmr.dat[CTRL_PERIODIC];
      irq_en_n   = wb_tmr.dat[CTRL_IRQ_EN];
      prescale_n = wb_tmr.dat[CTRL_PRESCALE_LSB +: PRE_W];
    end

    if (wr_compare) begin
      compare_n = wb_tmr.dat[CNT_W-1:0];
    end

    // Clear first so a match in the same cycle sets it again.
    if (wr_status && wb_tmr.dat[STATUS_MATCH]) begin
      match_n = 1'b0;
    end

    if (wr_count) begin
      // Software load beats the tick; no match is evaluated this cycle.
      count_n = wb_tmr.dat[CNT_W-1:0];
    end else if (tick) begin
      if (hit) begin
        match_n = 1'b1;
        if (periodic_q) begin
          count_n = '0;
        end else begin
          count_n = count_q + CNT_W'(1);
          // One-shot stop overrides a CTRL write landing on the same cycle.
          en_n    = 1'b0;
        end
      end else begin
        count_n = count_q + CNT_W'(1);
      end
    end
  end

  // Read mux; unused bits read 0.
  always_comb begin
    rd_dat = '0;
    unique case (sel)
      ADR_CTRL: begin
        rd_dat[CTRL_EN]                          = en_q;
        rd_dat[CTRL_PERIODIC]                    = periodic_q;
        rd_dat[CTRL_IRQ_EN]                      = irq_en_q;
        rd_dat[CTRL_PRESCALE_LSB +: PRE_W]       = prescale_q;
      end
      ADR_COUNT:   rd_dat = WB_DW'(count_q);
      ADR_COMPARE: rd_dat = WB_DW'(compare_q);
      ADR_STATUS:  rd_dat[STATUS_MATCH] = match_q;
      default:     rd_dat = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdt_q      <= '0;
    end else begin
      en_q       <= en_n;
      periodic_q <= periodic_n;
      irq_en_q   <= irq_en_n;
      prescale_q <= prescale_n;
      count_q    <= count_n;
      compare_q  <= compare_n;
      match_q    <= match_n;
      irq_q      <= match_n & irq_en_n;
      ack_q      <= wb_tmr.cyc & ~ack_q;
      // Read data is captured with the access and held until the next one.
      if (acc) begin
        rdt_q <= rd_dat;
      end
    end
  end

  assign wb_tmr.ack  = ack_q;
  assign wb_tmr.rdt  = rdt_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_wake_timer_wb.sv
// Self-checking bench for wake_timer_wb: directed scenarios plus randomized timer programs.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_wake_timer_wb;

  localparam logic [1:0] R_CTRL = 2'd0, R_COUNT = 2'd1, R_COMPARE = 2'd2, R_STATUS = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  wake_timer_wb_if bus_if ();

  wake_timer_wb #(
    .CNT_W (32),
    .PRE_W (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .wb_tmr      (bus_if),
    .o_timer_irq (irq)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_err = 0;
  int acc_edge;
  int irq_edge;
  logic [31:0] rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One bus access. at=0: as soon as possible; otherwise the access is sampled on edge 'at'.
  task automatic bus(input logic [1:0] r, input logic w, input logic [31:0] d, input int at);
    int tgt;
    int guard;
    tgt   = (at == 0) ? edge_cnt + 2 : at;
    guard = 0;
    while (edge_cnt < tgt - 1 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("sched", edge_cnt, tgt - 1);
    check("ack_idle", {31'd0, bus_if.ack}, 32'd0);
    bus_if.adr = {28'd0, r, 2'b00};
    bus_if.dat = d;
    bus_if.we  = w;
    bus_if.cyc = 1'b1;
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    check("ack", {31'd0, bus_if.ack}, 32'd1);
    rd_val = bus_if.rdt;
    bus_if.cyc = 1'b0;
    bus_if.we  = 1'b0;
  endtask

  task automatic wait_irq(input int max_cyc);
    irq_edge = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        irq_edge = edge_cnt;
        break;
      end
    end
  endtask

  // Reference: n clock edges after the enabling CTRL write, ticks = n/(P+1).
  // Match happens on tick number m = (C-S)+1; one-shot then parks at C+1,
  // periodic restarts from 0 and matches again every C+1 ticks.
  function automatic logic [31:0] exp_cnt(input logic [31:0] s, input logic [31:0] c,
                                          input int p, input bit per, input int n);
    longint unsigned t, m, k;
    logic [31:0] d;
    logic [63:0] kk;
    d = c - s;
    t = longint'(n / (p + 1));
    m = {32'd0, d} + 64'd1;
    if (t < m) return s + t[31:0];
    if (!per) return c + 32'd1;
    k  = (t - m) % ({32'd0, c} + 64'd1);
    kk = k;
    return kk[31:0];
  endfunction

  function automatic bit exp_match(input logic [31:0] s, input logic [31:0] c,
                                   input int p, input int n);
    longint unsigned t, m;
    logic [31:0] d;
    d = c - s;
    t = longint'(n / (p + 1));
    m = {32'd0, d} + 64'd1;
    return t >= m;
  endfunction

  int e0;
  int acks;
  logic [31:0] s, c, ctrl_v;
  int p, w;
  bit per, ien, mt;

  initial begin
    rst = 1'b1;
    bus_if.adr = '0; bus_if.dat = '0; bus_if.we = 1'b0; bus_if.cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("rst_rdt", bus_if.rdt, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(2'(i), 1'b0, 32'd0, 0);
      check("reset_read", rd_val, 32'd0);
    end

    // One-shot, prescale 0, compare 5.
    bus(R_COMPARE, 1'b1, 32'd5, 0);
    bus(R_CTRL, 1'b1, 32'h5, 0); e0 = acc_edge;
    wait_irq(50);
    check("oneshot_irq_edge", irq_edge - e0, 32'd6);
    bus(R_CTRL, 1'b0, 0, 0);   check("oneshot_ctrl", rd_val, 32'h4);
    bus(R_COUNT, 1'b0, 0, 0);  check("oneshot_count", rd_val, 32'd6);
    bus(R_STATUS, 1'b0, 0, 0); check("oneshot_status", rd_val, 32'd1);

    // Periodic, prescale 3, compare 2: match every 12 cycles.
    bus(R_CTRL, 1'b1, 0, 0);
    bus(R_STATUS, 1'b1, 1, 0);
    bus(R_COUNT, 1'b1, 0, 0);
    bus(R_COMPARE, 1'b1, 2, 0);
    bus(R_CTRL, 1'b1, 32'h307, 0); e0 = acc_edge;
    wait_irq(100);
    check("per_irq1_edge", irq_edge - e0, 32'd12);
    bus(R_STATUS, 1'b1, 1, 0);
    check("per_clr_irq", {31'd0, irq}, 32'd0);
    wait_irq(100);
    check("per_irq2_edge", irq_edge - e0, 32'd24);
    bus(R_COUNT, 1'b0, 0, 0);
    check("per_count", rd_val, exp_cnt(32'd0, 32'd2, 3, 1'b1, acc_edge - 1 - e0));

    // Wrap from all-ones without a match, then match at 0x10.
    bus(R_CTRL, 1'b1, 0, 0);
    bus(R_STATUS, 1'b1, 1, 0);
    bus(R_COUNT, 1'b1, 32'hFFFF_FFFF, 0);
    bus(R_COMPARE, 1'b1, 32'h10, 0);
    bus(R_CTRL, 1'b1, 32'h5, 0); e0 = acc_edge;
    bus(R_STATUS, 1'b0, 0, 0); check("wrap_no_match", rd_val, 32'd0);
    bus(R_COUNT, 1'b0, 0, 0);  check("wrap_count", rd_val, 32'd2);
    wait_irq(100);
    check("wrap_irq_edge", irq_edge - e0, 32'd18);
    bus(R_COUNT, 1'b0, 0, 0);  check("wrap_final_count", rd_val, 32'h11);

    // COUNT write on a tick cycle (prescale 1: ticks on even edges after enable).
    bus(R_CTRL, 1'b1, 0, 0);
    bus(R_STATUS, 1'b1, 1, 0);
    bus(R_COMPARE, 1'b1, 32'hFFFF, 0);
    bus(R_COUNT, 1'b1, 0, 0);
    bus(R_CTRL, 1'b1, 32'h101, 0); e0 = acc_edge;
    bus(R_COUNT, 1'b1, 32'h1234, e0 + 4);
    bus(R_COUNT, 1'b0, 0, 0);
    check("count_wr_on_tick", rd_val, 32'h1234);

    // STATUS clear in the same cycle as a new match: set wins.
    bus(R_CTRL, 1'b1, 0, 0);
    bus(R_STATUS, 1'b1, 1, 0);
    bus(R_COUNT, 1'b1, 0, 0);
    bus(R_COMPARE, 1'b1, 32'd10, 0);
    bus(R_CTRL, 1'b1, 32'h5, 0); e0 = acc_edge;
    bus(R_STATUS, 1'b1, 1, e0 + 11);
    check("collide_irq", {31'd0, irq}, 32'd1);
    bus(R_STATUS, 1'b0, 0, 0);
    check("collide_status", rd_val, 32'd1);

    // Reset during a pending access while counting.
    bus(R_CTRL, 1'b1, 32'h7, 0);
    bus(R_CTRL, 1'b0, 0, 0);
    check("pre_rst_ctrl", rd_val, 32'h7);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    bus_if.adr = 32'h4; bus_if.we = 1'b0; bus_if.cyc = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("midrst_rdt", bus_if.rdt, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    bus_if.cyc = 1'b0; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus(R_COUNT, 1'b0, 0, 0); check("postrst_count", rd_val, 32'd0);
    bus(R_CTRL, 1'b0, 0, 0);  check("postrst_ctrl", rd_val, 32'd0);

    // Held cyc: ack every other cycle.
    @(posedge clk); #1;
    bus_if.adr = 32'h8; bus_if.cyc = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      acks += int'(bus_if.ack);
    end
    bus_if.cyc = 1'b0;
    check("held_cyc_acks", acks, 32'd2);

    // Randomized timer programs against the arithmetic reference.
    for (int it = 0; it < 12; it++) begin
      s   = $urandom;
      c   = s + 32'($urandom_range(0, 12));
      p   = int'($urandom_range(0, 3));
      per = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      w   = int'($urandom_range(0, 50));
      ctrl_v = 32'h1 | (32'(p) << 8) | (ien ? 32'h4 : 32'h0) | (per ? 32'h2 : 32'h0);
      bus(R_CTRL, 1'b1, 0, 0);
      bus(R_STATUS, 1'b1, 1, 0);
      bus(R_COUNT, 1'b1, s, 0);
      bus(R_COMPARE, 1'b1, c, 0);
      bus(R_CTRL, 1'b1, ctrl_v, 0); e0 = acc_edge;
      repeat (w) @(posedge clk);
      #1;
      bus(R_COUNT, 1'b0, 0, 0);
      check("rnd_count", rd_val, exp_cnt(s, c, p, per, acc_edge - 1 - e0));
      bus(R_STATUS, 1'b0, 0, 0);
      check("rnd_status", rd_val, {31'd0, exp_match(s, c, p, acc_edge - 1 - e0)});
      mt = exp_match(s, c, p, acc_edge - e0);
      check("rnd_irq", {31'd0, irq}, {31'd0, mt & ien});
      bus(R_CTRL, 1'b0, 0, 0);
      mt = exp_match(s, c, p, acc_edge - 1 - e0);
      check("rnd_ctrl", rd_val, (per || !mt) ? ctrl_v : (ctrl_v & ~32'h1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
